ram_read_scanner: RTL and testbench

- Reader side of the 32x8 single-port RAM (ramlpm) that is loaded by hand from switches.
- Walks the RAM address space from 0 to DEPTH-1 and drives the RAM read address.
- Absorbs the RAM's one-cycle registered read latency.
- Holds each address/data pair stable for the HEX display decoders. Advance is by single step or by an internal timer.

---
 rtl/ram_scan_pkg.sv | 17 +
 rtl/ram_read_scanner_rise_detect.sv | 31 +++
 rtl/ram_read_scanner.sv | 180 ++++++++++++++++++
 tb/tb_ram_read_scanner.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_scan_pkg.sv
// Shared types and default sizes for the RAM read scanner.
package ram_scan_pkg;

    localparam int ADDR_W_DEF     = 5;
    localparam int DATA_W_DEF     = 8;
    localparam int DEPTH_DEF      = 32;
    localparam int TICK_DIV_50MHZ = 25000000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHOW  = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_e;

endpackage

// File: rtl/ram_read_scanner_rise_detect.sv
// 1-bit registered rising-edge detector; a held input yields one event.
module rise_detect (
    input  logic clock,
    input  logic resetn,
    input  logic din,
    output logic rise
);

    logic cur_q, cur_d;
    logic prev_q, prev_d;

    // Next values: sample the input, then delay it once more for comparison
    always_comb begin
        cur_d  = din;
        prev_d = cur_q;
    end

    // Edge-detect registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            prev_q <= prev_d;
        end
    end

    assign rise = cur_q & ~prev_q;

endmodule

// File: rtl/ram_read_scanner.sv
// Scans a registered-read RAM from address 0 to DEPTH-1 and holds each
// address/data pair for display. Advance by step key or internal timer.
// Optional match counter enabled by defining SCAN_MATCH_EN.
module ram_read_scanner
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int TICK_DIV = TICK_DIV_50MHZ
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              step,
    input  logic              auto_mode,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy,
    output logic              done
`ifdef SCAN_MATCH_EN
    ,
    input  logic [DATA_W-1:0] match_val,
    output logic              match_hit,
    output logic [ADDR_W:0]   match_cnt
`endif
);

    localparam int TICK_W = $clog2(TICK_DIV);

    logic start_rise, step_rise;

    rise_detect u_start_rd (
        .clock  (clock),
        .resetn (resetn),
        .din    (start),
        .rise   (start_rise)
    );

    rise_detect u_step_rd (
        .clock  (clock),
        .resetn (resetn),
        .din    (step),
        .rise   (step_rise)
    );

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              advance;
`ifdef SCAN_MATCH_EN
    logic              match_hit_q, match_hit_d;
    logic [ADDR_W:0]   match_cnt_q, match_cnt_d;
`endif

    // Next-state logic: scan FSM, tick counter and display capture
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        busy_d       = busy_q;
        done_d       = done_q;
        tick_d       = tick_q;
        advance      = 1'b0;
`ifdef SCAN_MATCH_EN
        match_hit_d  = match_hit_q;
        match_cnt_d  = match_cnt_q;
`endif
        case (state_q)
            ST_ISSUE: begin
                // RAM samples rd_addr on this edge; data appears next cycle
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                disp_data_d  = rd_data;
                disp_addr_d  = rd_addr_q;
                disp_valid_d = 1'b1;
                tick_d       = '0;
                state_d      = ST_SHOW;
`ifdef SCAN_MATCH_EN
                match_hit_d = (rd_data == match_val);
                if ((rd_data == match_val) && (match_cnt_q < (ADDR_W+1)'(DEPTH)))
                    match_cnt_d = match_cnt_q + (ADDR_W+1)'(1);
`endif
            end
            ST_SHOW: begin
                if (auto_mode) begin
                    if (tick_q == TICK_W'(TICK_DIV - 1))
                        advance = 1'b1;
                    else
                        tick_d = tick_q + TICK_W'(1);
                end else begin
                    tick_d  = '0;
                    advance = step_rise;
                end
                if (advance) begin
`ifdef SCAN_MATCH_EN
                    match_hit_d = 1'b0;
`endif
                    if (rd_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        rd_addr_d    = rd_addr_q + ADDR_W'(1);
                        disp_valid_d = 1'b0;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            default: ;
        endcase
        // A start rise restarts from address 0 in any state and wins over advance
        if (start_rise) begin
            state_d      = ST_ISSUE;
            rd_addr_d    = '0;
            disp_valid_d = 1'b0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            tick_d       = '0;
`ifdef SCAN_MATCH_EN
            match_hit_d  = 1'b0;
            match_cnt_d  = '0;
`endif
        end
    end

    // State and output registers, all cleared by synchronous reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tick_q       <= '0;
`ifdef SCAN_MATCH_EN
            match_hit_q  <= 1'b0;
            match_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tick_q       <= tick_d;
`ifdef SCAN_MATCH_EN
            match_hit_q  <= match_hit_d;
            match_cnt_q  <= match_cnt_d;
`endif
        end
    end

    assign rd_addr    = rd_addr_q;
    assign disp_addr  = disp_addr_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef SCAN_MATCH_EN
    assign match_hit  = match_hit_q;
    assign match_cnt  = match_cnt_q;
`endif

endmodule

// File: tb/tb_ram_read_scanner.sv
// Scoreboard bench for ram_read_scanner with a registered-read RAM model.
module tb_ram_read_scanner;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int DEPTH = 32;
    localparam int TD = 8;

    logic          clock = 1'b0;
    logic          resetn, start, step, auto_mode;
    logic [AW-1:0] rd_addr, disp_addr;
    logic [DW-1:0] rd_data, disp_data;
    logic          disp_valid, busy, done;
    logic [DW-1:0] match_val;
`ifdef SCAN_MATCH_EN
    logic          match_hit;
    logic [AW:0]   match_cnt;
`endif

    always #5 clock = ~clock;

    ram_read_scanner #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TICK_DIV(TD)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .step       (step),
        .auto_mode  (auto_mode),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .busy       (busy),
        .done       (done)
`ifdef SCAN_MATCH_EN
        ,
        .match_val  (match_val),
        .match_hit  (match_hit),
        .match_cnt  (match_cnt)
`endif
    );

    // RAM model: contents and one-cycle registered read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        bit hit;
        int t_ref;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   auto_chk = 0;
    int   pos = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input int a, input int t);
        exp_t e;
        e.addr  = a;
        e.data  = int'(mem[a]);
        e.hit   = (mem[a] == match_val);
        e.t_ref = t;
        q.push_back(e);
    endtask

    // Monitor: each new coherent display word is popped and compared
    exp_t e_m;
    logic pv = 1'b0;
    int   last_rise = -1;
    always @(negedge clock) begin
        if (!auto_chk) last_rise = -1;
        if (resetn && disp_valid && !pv) begin
            if (q.size() == 0) begin
                chk("unexpected_word", 32'(disp_addr), 32'hFFFF);
            end else begin
                e_m = q.pop_front();
                chk("disp_addr", 32'(disp_addr), 32'(e_m.addr));
                chk("disp_data", 32'(disp_data), 32'(e_m.data));
                chk("busy_while_show", 32'(busy), 32'd1);
`ifdef SCAN_MATCH_EN
                chk("match_hit", 32'(match_hit), 32'(e_m.hit));
`endif
                if (e_m.t_ref >= 0) chk("latency", 32'(cyc - e_m.t_ref), 32'd4);
                if (auto_chk && last_rise >= 0) chk("auto_period", 32'(cyc - last_rise), 32'(TD + 2));
                last_rise = cyc;
            end
        end
        pv = resetn ? disp_valid : 1'b0;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_shown(input int bound);
        int n = 0;
        while (!(q.size() == 0 && disp_valid) && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (n >= bound) chk("timeout_show", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (n >= bound) chk("timeout_done", 32'(done), 32'd1);
    endtask

    task automatic do_start();
        q.delete();
        pos = 0;
        start = 1'b1;
        push_word(0, cyc);
        tick($urandom_range(1, 5));
        start = 1'b0;
        tick(3);
        wait_shown(30);
    endtask

    task automatic do_step();
        if (pos < DEPTH - 1) begin
            pos++;
            push_word(pos, cyc);
        end
        step = 1'b1;
        tick($urandom_range(1, 12));
        step = 1'b0;
        tick(3);
        wait_shown(30);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_addr"},    32'(rd_addr),    32'd0);
        chk({tag, "_disp_addr"},  32'(disp_addr),  32'd0);
        chk({tag, "_disp_data"},  32'(disp_data),  32'd0);
        chk({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
`ifdef SCAN_MATCH_EN
        chk({tag, "_match_cnt"},  32'(match_cnt),  32'd0);
`endif
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; step = 1'b0; auto_mode = 1'b0;
        match_val = 8'h0F;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);
        tick(2);
        tick(1);
        chk_reset_outputs("reset");
        resetn = 1'b1;
        tick(3);

        // First word after start, then single steps through the whole RAM
        do_start();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_done", 32'(done), 32'd0);
        for (int i = 1; i < DEPTH; i++) do_step();
        chk("t2_last_data", 32'(disp_data), 32'h5D);
        do_step();
        wait_done(20);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_disp_addr", 32'(disp_addr), 32'(DEPTH - 1));
        chk("t2_valid_held", 32'(disp_valid), 32'd1);
        // Steps after the last word do nothing
        do_step();
        tick(10);
        chk("post_done_addr", 32'(disp_addr), 32'(DEPTH - 1));
        chk("post_done_done", 32'(done), 32'd1);

        // Second step rise landing in WAIT is dropped
        do_start();
        chk("restart_done", 32'(done), 32'd0);
        pos = 1;
        push_word(1, cyc);
        step = 1'b1; tick(1);
        step = 1'b0; tick(1);
        step = 1'b1; tick(1);
        step = 1'b0; tick(10);
        wait_shown(30);
        chk("drop_step_addr", 32'(disp_addr), 32'd1);

        // Random contents with matches only at 5 and 9; mid-scan restart
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'($urandom_range(0, 255));
            if (mem[i] == 8'h0F) mem[i] = 8'h10;
        end
        mem[5] = 8'h0F;
        mem[9] = 8'h0F;
        do_start();
        begin
            int k = $urandom_range(10, 25);
            for (int i = 0; i < k; i++) do_step();
        end
        do_start();
        chk("t4_restart_addr", 32'(disp_addr), 32'd0);
        chk("t4_restart_done", 32'(done), 32'd0);
        for (int i = 1; i < DEPTH; i++) do_step();
        do_step();
        wait_done(20);
        chk("t6_done", 32'(done), 32'd1);
`ifdef SCAN_MATCH_EN
        chk("t6_match_cnt", 32'(match_cnt), 32'd2);
`endif

        // Timer-driven scan
        auto_chk = 1'b1;
        auto_mode = 1'b1;
        tick(1);
        q.delete();
        start = 1'b1;
        push_word(0, cyc);
        for (int i = 1; i < DEPTH; i++) push_word(i, -1);
        tick(2);
        start = 1'b0;
        wait_done(DEPTH * (TD + 2) + 50);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_disp_addr", 32'(disp_addr), 32'(DEPTH - 1));
        chk("t3_queue_empty", 32'(q.size()), 32'd0);
        auto_mode = 1'b0;
        tick(2);
        auto_chk = 1'b0;
        tick(2);

        // Reset in the middle of a scan
        do_start();
        for (int i = 0; i < 7; i++) do_step();
        chk("t5_pre_addr", 32'(disp_addr), 32'd7);
        resetn = 1'b0;
        tick(1);
        chk_reset_outputs("midreset");
        q.delete();
        resetn = 1'b1;
        tick(20);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_valid", 32'(disp_valid), 32'd0);
        chk("t5_idle_addr", 32'(rd_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute safety bound on run length
    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d required finish", cyc);
        $fatal(1);
    end

endmodule
